// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
//
// Bundles the fetch-stage control/datapath signals around pc_sequencer.
//
//   stall, branch_taken, jal, jalr : pipeline control from decode/execute
//   next_pc                        : pc_adder result for the current pc_src
//   imem_ready                     : instruction memory accepts the fetch at pc
//   pc                             : architectural PC (pc_adder input, imem address)
//   pc_src                         : pc_adder source select (00 +4, 01 +imm, 10 rs1+imm, 11 hold)
//   imem_req                       : fetch request at pc
//   flush                          : kill younger in-flight instructions
//   misaligned                     : sticky misaligned-target trap flag
//   state                          : debug view of the sequencer state
//
// master : the sequencer side (drives pc/pc_src/imem_req/flush/misaligned/state)
// slave  : the surrounding pipeline/adder/memory side
interface pc_sequencer_if;
    logic        stall;
    logic        branch_taken;
    logic        jal;
    logic        jalr;
    logic [31:0] next_pc;
    logic        imem_ready;
    logic [31:0] pc;
    logic [1:0]  pc_src;
    logic        imem_req;
    logic        flush;
    logic        misaligned;
    logic [1:0]  state;

    modport master (
        input  stall, branch_taken, jal, jalr, next_pc, imem_ready,
        output pc, pc_src, imem_req, flush, misaligned, state
    );

    modport slave (
        output stall, branch_taken, jal, jalr, next_pc, imem_ready,
        input  pc, pc_src, imem_req, flush, misaligned, state
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
//
// Fetch-stage controller. Owns the architectural PC, picks the pc_adder
// source each cycle and loads the adder result when fetch may advance.
// Handles instruction-memory backpressure, post-redirect flush bubbles and
// traps (halts) on a misaligned PC target.
//
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : pc_sequencer_if.master (control inputs, adder result, imem
//          handshake, PC/pc_src/imem_req/flush/misaligned/state outputs)
//
// Parameters:
//   RESET_PC     : PC value loaded on reset
//   FLUSH_CYCLES : bubble cycles after a redirect (1..15)
module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    pc_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        FLUSH = 2'b10,
        HALT  = 2'b11
    } state_t;

    localparam logic [1:0] SRC_SEQ  = 2'b00;
    localparam logic [1:0] SRC_IMM  = 2'b01;
    localparam logic [1:0] SRC_REG  = 2'b10;
    localparam logic [1:0] SRC_HOLD = 2'b11;

    // The counter holds the number of flush cycles still to follow the
    // current one, so it is reloaded with one less than the bubble count.
    localparam logic [3:0] CNT_RELOAD = 4'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        mis_q, mis_d;

    logic [1:0]  src_sel;
    logic        fetch_req;
    logic        flush_active;
    logic        redirect;
    logic        pc_load;

    assign redirect = bus.jalr | bus.jal | bus.branch_taken;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= 4'd0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
        end
    end

    // Next-state logic. Any non-hold source in FETCH/FLUSH is a would-be PC
    // load; a misaligned adder result turns that load into a trap instead.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        pc_load = ((state_q == FETCH) || (state_q == FLUSH)) && (src_sel != SRC_HOLD);

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH, FLUSH: begin
                if (pc_load) begin
                    if (bus.next_pc[1:0] != 2'b00) begin
                        mis_d   = 1'b1;
                        state_d = HALT;
                    end else begin
                        pc_d = bus.next_pc;
                        if (redirect) begin
                            cnt_d   = CNT_RELOAD;
                            state_d = FLUSH;
                        end
                    end
                end else if (state_q == FLUSH) begin
                    if (cnt_q == 4'd0) begin
                        state_d = FETCH;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // Output logic. Redirects win over stall/backpressure; in FLUSH only a
    // redirect can select a non-hold source.
    always_comb begin
        src_sel      = SRC_HOLD;
        fetch_req    = 1'b0;
        flush_active = 1'b0;

        case (state_q)
            FETCH: begin
                fetch_req = 1'b1;
                if (bus.jalr) begin
                    src_sel = SRC_REG;
                end else if (bus.jal || bus.branch_taken) begin
                    src_sel = SRC_IMM;
                end else if (bus.stall || !bus.imem_ready) begin
                    src_sel = SRC_HOLD;
                end else begin
                    src_sel = SRC_SEQ;
                end
            end
            FLUSH: begin
                flush_active = 1'b1;
                if (bus.jalr) begin
                    src_sel = SRC_REG;
                end else if (bus.jal || bus.branch_taken) begin
                    src_sel = SRC_IMM;
                end
            end
            HALT: begin
                flush_active = 1'b1;
            end
            default: begin
                src_sel = SRC_HOLD;
            end
        endcase
    end

    assign bus.pc         = pc_q;
    assign bus.pc_src     = src_sel;
    assign bus.imem_req   = fetch_req;
    assign bus.flush      = flush_active;
    assign bus.misaligned = mis_q;
    assign bus.state      = state_q;

endmodule
